// File: rtl/neuron_argmax.sv
// neuron_argmax: final classification stage of the inference datapath.
// After Start, waits SETTLE_CYCLES for the dot products to settle, snapshots
// all NEURONS values at once, then scans them one per cycle and reports the
// index and value of the largest signed entry with a one-cycle Done pulse.
// Ties keep the lowest index because only a strictly greater value wins.
module neuron_argmax #(
  parameter int NEURONS       = 10,
  parameter int VAL_SIZE      = 26,
  parameter int IDX_SIZE      = 4,
  parameter int SETTLE_CYCLES = 40
) (
  input  logic                        clk,
  input  logic                        GlobalReset,
  input  logic                        Start,
  input  logic [NEURONS*VAL_SIZE-1:0] Values,
  output logic                        Busy,
  output logic                        Done,
  output logic [IDX_SIZE-1:0]         ClassIdx,
  output logic [VAL_SIZE-1:0]         MaxValue
);

  localparam int                 CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_SIZE-1:0] PTR_LAST = IDX_SIZE'(NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_SIZE-1:0] ptr;
  logic [IDX_SIZE-1:0] best_idx;
  logic [VAL_SIZE-1:0] best_val;
  logic [VAL_SIZE-1:0] snap [NEURONS];

  logic [VAL_SIZE-1:0] cand_val;
  logic [IDX_SIZE-1:0] next_idx;
  logic [VAL_SIZE-1:0] next_val;

  // Running best after considering the snapshot entry under the scan pointer.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cand_val = snap[ptr];
    next_idx = best_idx;
    next_val = best_val;
    if ($signed(cand_val) > $signed(best_val)) begin
      next_idx = ptr;
      next_val = cand_val;
    end
  end

  // Control FSM, snapshot capture, sequential scan and registered result outputs.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      best_idx <= '0;
      best_val <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      ClassIdx <= '0;
      MaxValue <= '0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it takes the reset like any other state.
      for (int n = 0; n < NEURONS; n++) snap[n] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            state <= S_WAIT;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          for (int n = 0; n < NEURONS; n++) snap[n] <= Values[n*VAL_SIZE +: VAL_SIZE];
          best_val <= Values[VAL_SIZE-1:0];
          best_idx <= '0;
          ptr      <= IDX_SIZE'(1);
          if (NEURONS > 1) begin
            state <= S_COMPARE;
          end else begin
            // Single neuron: it wins outright, straight from the input.
            state    <= S_DONE;
            Done     <= 1'b1;
            ClassIdx <= '0;
            MaxValue <= Values[VAL_SIZE-1:0];
          end
        end
        S_COMPARE: begin
          best_val <= next_val;
          best_idx <= next_idx;
          ptr      <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            state    <= S_DONE;
            Done     <= 1'b1;
            ClassIdx <= next_idx;
            MaxValue <= next_val;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_argmax.sv
// Testbench for neuron_argmax: a timeline-level reference model (run-relative
// cycle number, argmax over the values present in the capture cycle) checked
// against the DUT outputs every cycle, plus directed scenarios with literal
// expected results and randomized runs.
module tb_neuron_argmax;

  localparam int N   = 10;
  localparam int V   = 26;
  localparam int I   = 4;
  localparam int SC  = 40;
  localparam int RUN = SC + N + 1;   // run-relative cycle carrying Done (51)

  logic           clk = 1'b0;
  logic           GlobalReset;
  logic           Start;
  logic [N*V-1:0] Values;
  logic           Busy;
  logic           Done;
  logic [I-1:0]   ClassIdx;
  logic [V-1:0]   MaxValue;

  neuron_argmax #(
    .NEURONS      (N),
    .VAL_SIZE     (V),
    .IDX_SIZE     (I),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .Start      (Start),
    .Values     (Values),
    .Busy       (Busy),
    .Done       (Done),
    .ClassIdx   (ClassIdx),
    .MaxValue   (MaxValue)
  );

  always #5 clk = ~clk;

  int cyc        = 0;
  int errors     = 0;
  int checks     = 0;
  int done_count = 0;
  int last_done  = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Largest signed value, then the lowest index holding it.
  function automatic void argmax(input logic [N*V-1:0] vals,
                                 output logic [I-1:0] idx, output logic [V-1:0] mx);
    logic signed [V-1:0] best;
    best = vals[V-1:0];
    for (int n = 1; n < N; n++)
      if ($signed(vals[n*V +: V]) > best) best = vals[n*V +: V];
    mx  = best;
    idx = '0;
    for (int n = N - 1; n >= 0; n--)
      if (vals[n*V +: V] == best) idx = I'(n);
  endfunction

  // Reference model: tracks where in a run we are and what the result must be.
  bit           m_active = 1'b0;
  int           m_rc     = 0;
  logic [I-1:0] m_idx    = '0;
  logic [V-1:0] m_max    = '0;
  logic [I-1:0] m_res_idx;
  logic [V-1:0] m_res_max;

  always @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      m_active = 1'b0;
      m_rc     = 0;
      m_idx    = '0;
      m_max    = '0;
    end else if (m_active) begin
      if (m_rc == SC + 1) argmax(Values, m_res_idx, m_res_max);
      if (m_rc == RUN) begin
        m_active = 1'b0;
      end else begin
        m_rc++;
        if (m_rc == RUN) begin
          m_idx = m_res_idx;
          m_max = m_res_max;
        end
      end
    end else if (Start) begin
      m_active = 1'b1;
      m_rc     = 1;
    end
  end

  // Compare process: outputs are meaningful every cycle (results hold).
  always @(negedge clk) begin
    check("busy", Busy, m_active);
    check("done", Done, m_active && (m_rc == RUN));
    check("class_idx", ClassIdx, m_idx);
    check("max_value", MaxValue, m_max);
    if (Done === 1'b1) begin
      done_count++;
      last_done = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic set_val(input int n, input logic [V-1:0] v);
    Values[n*V +: V] = v;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic ramp_values();
    for (int n = 0; n < N; n++) set_val(n, V'(100 * n));
  endtask

  task automatic random_values();
    logic [V-1:0] pool [3];
    pool[0] = 26'h1FFFFFF;
    pool[1] = 26'h2000000;
    pool[2] = 26'h0000000;
    for (int n = 0; n < N; n++) begin
      if ($urandom_range(0, 3) == 0) set_val(n, pool[$urandom_range(0, 2)]);
      else                           set_val(n, V'($urandom));
    end
  endtask

  // Runs one full job from the current cycle and checks timing and result literals.
  task automatic run_and_check(input string name, input logic [I-1:0] exp_idx,
                               input logic [V-1:0] exp_max);
    int s, d0;
    s  = cyc;
    d0 = done_count;
    pulse_start();
    step_n(RUN);
    check({name, "_done_cnt"}, done_count - d0, 1);
    check({name, "_done_cyc"}, last_done - s, RUN);
    check({name, "_idx"}, ClassIdx, exp_idx);
    check({name, "_max"}, MaxValue, exp_max);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, d0, hold;

    // Reset and idle.
    GlobalReset = 1'b1;
    Start       = 1'b0;
    Values      = '0;
    step_n(3);
    GlobalReset = 1'b0;
    step_n(100);
    check("idle_done_cnt", done_count, 0);
    check("idle_busy", Busy, 1'b0);
    check("idle_idx", ClassIdx, 4'd0);
    check("idle_max", MaxValue, 26'd0);

    // Basic max: neuron n = 100*n.
    ramp_values();
    run_and_check("basic", 4'd9, 26'd900);

    // Signed values with a single most-positive entry.
    for (int n = 0; n < N; n++) set_val(n, 26'h2000000);
    set_val(0, V'(-5));
    set_val(1, V'(-1));
    set_val(2, V'(-1));
    set_val(3, V'(-300));
    set_val(7, 26'h1FFFFFF);
    run_and_check("signed", 4'd7, 26'h1FFFFFF);

    // All equal: lowest index wins.
    for (int n = 0; n < N; n++) set_val(n, V'(-3));
    run_and_check("ties", 4'd0, 26'h3FFFFFD);

    // Snapshot stability: values change right after the capture cycle.
    ramp_values();
    s  = cyc;
    d0 = done_count;
    pulse_start();
    step_n(41);
    set_val(2, 26'h0FFFFFF);
    step_n(10);
    check("snap_done_cyc", last_done - s, RUN);
    check("snap_idx", ClassIdx, 4'd9);
    check("snap_max", MaxValue, 26'd900);

    // Start pulses while busy (including in the Done cycle) are ignored.
    random_values();
    s  = cyc;
    d0 = done_count;
    pulse_start();               // cycle 0
    step_n(9);
    pulse_start();               // cycle 10
    step_n(34);
    pulse_start();               // cycle 45
    step_n(5);
    pulse_start();               // cycle 51 (Done cycle)
    check("ignore_done_cnt", done_count - d0, 1);
    check("ignore_done_cyc", last_done - s, RUN);
    pulse_start();               // cycle 52: back-to-back run
    step_n(51);
    check("b2b_done_cnt", done_count - d0, 2);
    check("b2b_done_cyc", last_done - s, 103);

    // Reset mid-run aborts without Done; a fresh run afterwards is correct.
    ramp_values();
    s  = cyc;
    d0 = done_count;
    pulse_start();
    step_n(44);                  // cycle 45
    GlobalReset = 1'b1;
    step();
    check("abort_busy", Busy, 1'b0);
    GlobalReset = 1'b0;
    step_n(4);                   // cycle 50
    check("abort_done_cnt", done_count - d0, 0);
    check("abort_idx", ClassIdx, 4'd0);
    check("abort_max", MaxValue, 26'd0);
    set_val(4, 26'd5000);
    pulse_start();
    step_n(51);
    check("rerun_done_cnt", done_count - d0, 1);
    check("rerun_done_cyc", last_done - s, 101);
    check("rerun_idx", ClassIdx, 4'd4);
    check("rerun_max", MaxValue, 26'd5000);

    // Randomized runs: multi-cycle Start, values churning throughout.
    for (int r = 0; r < 20; r++) begin
      random_values();
      step_n($urandom_range(0, 3));
      s    = cyc;
      d0   = done_count;
      hold = $urandom_range(1, 3);
      Start = 1'b1;
      step_n(hold);
      Start = 1'b0;
      while (cyc < s + RUN + 1) begin
        if ($urandom_range(0, 1) == 1) set_val($urandom_range(0, N - 1), V'($urandom));
        step();
      end
      check("rand_done_cnt", done_count - d0, 1);
      check("rand_done_cyc", last_done - s, RUN);
    end

    step_n(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
